// File: rtl/regfile_sb.sv
// Parametrised two-read / two-write register file with a per-register load scoreboard.
// Port A carries ALU results and port B carries load returns. Port B also retires busy bits.

module regfile_sb_rdport #(
  parameter int WIDTH    = 16,
  parameter int COUNT    = 8,
  parameter int AW       = $clog2(COUNT),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [COUNT-1:0][WIDTH-1:0] regs,
  input  logic [COUNT-1:0]            busy,
  input  logic [AW-1:0]               rd_num,
  input  logic                        wa_en,
  input  logic [AW-1:0]               wa_num,
  input  logic [WIDTH-1:0]            wa_data,
  input  logic                        wb_en,
  input  logic [AW-1:0]               wb_num,
  input  logic [WIDTH-1:0]            wb_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_busy
);
  always_comb begin
    rd_data = regs[rd_num];
    rd_busy = busy[rd_num];
    if (BYPASS != 0) begin
      // Port A is checked last so it wins, matching what gets stored on a conflict
      if (wb_en && wb_num == rd_num) begin
        rd_data = wb_data;
        rd_busy = 1'b0;
      end
      if (wa_en && wa_num == rd_num) rd_data = wa_data;
    end
    if (ZERO_REG != 0 && rd_num == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int COUNT    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_num1,
  input  logic [AW-1:0]    rd_num2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             rd_busy1,
  output logic             rd_busy2,
  input  logic             wa_en,
  input  logic [AW-1:0]    wa_num,
  input  logic [WIDTH-1:0] wa_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_num,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_num,
  output logic             claim_ready
);
  logic [COUNT-1:0][WIDTH-1:0] regs;
  logic [COUNT-1:0]            busy, busy_nxt;
  logic [1:0][AW-1:0]          rd_nums;
  logic [1:0][WIDTH-1:0]       rd_datas;
  logic [1:0]                  rd_busys;
  logic                        zero_claim, wa_ok, wb_ok, claim_acc;

  assign zero_claim  = (ZERO_REG != 0) && claim_num == '0;
  assign claim_ready = zero_claim || !busy[claim_num];
  assign claim_acc   = claim_en && claim_ready && !zero_claim;
  assign wa_ok       = wa_en && !(ZERO_REG != 0 && wa_num == '0);
  assign wb_ok       = wb_en && !(ZERO_REG != 0 && wb_num == '0);

  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_num] = 1'b0;
    // A claim can only be accepted on a non-busy register; if that coincides
    // with a stray load return to it, the new outstanding load must stay tracked.
    if (claim_acc) busy_nxt[claim_num] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (wb_ok) regs[wb_num] <= wb_data;
      if (wa_ok) regs[wa_num] <= wa_data;
    end
  end

  assign rd_nums = {rd_num2, rd_num1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    regfile_sb_rdport #(
      .WIDTH(WIDTH), .COUNT(COUNT), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs    (regs),
      .busy    (busy),
      .rd_num  (rd_nums[p]),
      .wa_en   (wa_en),
      .wa_num  (wa_num),
      .wa_data (wa_data),
      .wb_en   (wb_en),
      .wb_num  (wb_num),
      .wb_data (wb_data),
      .rd_data (rd_datas[p]),
      .rd_busy (rd_busys[p])
    );
  end

  assign rd_data1 = rd_datas[0];
  assign rd_data2 = rd_datas[1];
  assign rd_busy1 = rd_busys[0];
  assign rd_busy2 = rd_busys[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing file, a non-bypassing file and a
// zero-register file all share one stimulus stream.
module tb_regfile_sb;
  logic        clk, rst_n;
  logic [2:0]  rd_num1, rd_num2, wa_num, wb_num, claim_num;
  logic [15:0] wa_data, wb_data;
  logic        wa_en, wb_en, claim_en;
  logic [15:0] d1 [3];
  logic [15:0] d2 [3];
  logic        b1 [3];
  logic        b2 [3];
  logic        cr [3];
  int          errors = 0, checks = 0;

  // 0: BYPASS=1 ZERO_REG=0, 1: BYPASS=0, 2: ZERO_REG=1
  regfile_sb #(.WIDTH(16), .COUNT(8), .BYPASS(1), .ZERO_REG(0)) u_main (
    .clk(clk), .rst_n(rst_n), .rd_num1(rd_num1), .rd_num2(rd_num2),
    .rd_data1(d1[0]), .rd_data2(d2[0]), .rd_busy1(b1[0]), .rd_busy2(b2[0]),
    .wa_en(wa_en), .wa_num(wa_num), .wa_data(wa_data),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .claim_en(claim_en), .claim_num(claim_num), .claim_ready(cr[0]));
  regfile_sb #(.WIDTH(16), .COUNT(8), .BYPASS(0), .ZERO_REG(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_num1(rd_num1), .rd_num2(rd_num2),
    .rd_data1(d1[1]), .rd_data2(d2[1]), .rd_busy1(b1[1]), .rd_busy2(b2[1]),
    .wa_en(wa_en), .wa_num(wa_num), .wa_data(wa_data),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .claim_en(claim_en), .claim_num(claim_num), .claim_ready(cr[1]));
  regfile_sb #(.WIDTH(16), .COUNT(8), .BYPASS(1), .ZERO_REG(1)) u_z (
    .clk(clk), .rst_n(rst_n), .rd_num1(rd_num1), .rd_num2(rd_num2),
    .rd_data1(d1[2]), .rd_data2(d2[2]), .rd_busy1(b1[2]), .rd_busy2(b2[2]),
    .wa_en(wa_en), .wa_num(wa_num), .wa_data(wa_data),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .claim_en(claim_en), .claim_num(claim_num), .claim_ready(cr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic wa_en; logic [2:0] wa_num; logic [15:0] wa_data;
    logic wb_en; logic [2:0] wb_num; logic [15:0] wb_data;
    logic cl_en; logic [2:0] cl_num;
    logic [2:0] r1, r2;
    logic [15:0] e_d1, e_d2; logic e_b1, e_b2, e_cr;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; claim_en = 0;
    wa_num = 0; wb_num = 0; claim_num = 0;
    wa_data = 0; wb_data = 0;
  endtask

  vec_t vt [14];

  initial begin
    // Bypassing instance, starting from a freshly reset file
    vt[0]  = '{0,0,16'h0,    0,0,16'h0,    0,0, 0,7, 16'h0000,16'h0000,0,0,1};
    vt[1]  = '{1,3,16'h1234, 1,3,16'hBEEF, 0,0, 3,3, 16'h1234,16'h1234,0,0,1};
    vt[2]  = '{0,0,16'h0,    0,0,16'h0,    0,0, 3,5, 16'h1234,16'h0000,0,0,1};
    vt[3]  = '{0,0,16'h0,    0,0,16'h0,    1,5, 5,3, 16'h0000,16'h1234,0,0,1};
    vt[4]  = '{0,0,16'h0,    0,0,16'h0,    1,5, 5,3, 16'h0000,16'h1234,1,0,0};
    vt[5]  = '{0,0,16'h0,    1,5,16'h00AA, 0,5, 5,3, 16'h00AA,16'h1234,0,0,0};
    vt[6]  = '{0,0,16'h0,    0,0,16'h0,    0,5, 5,5, 16'h00AA,16'h00AA,0,0,1};
    vt[7]  = '{0,0,16'h0,    0,0,16'h0,    1,2, 2,5, 16'h0000,16'h00AA,0,0,1};
    vt[8]  = '{0,0,16'h0,    1,2,16'h0022, 1,2, 2,2, 16'h0022,16'h0022,0,0,0};
    vt[9]  = '{0,0,16'h0,    0,0,16'h0,    1,2, 2,5, 16'h0022,16'h00AA,0,0,1};
    vt[10] = '{0,0,16'h0,    0,0,16'h0,    0,2, 2,5, 16'h0022,16'h00AA,1,0,0};
    vt[11] = '{1,6,16'h6666, 0,0,16'h0,    0,2, 6,2, 16'h6666,16'h0022,0,1,0};
    vt[12] = '{0,0,16'h0,    1,2,16'h2222, 0,2, 6,2, 16'h6666,16'h2222,0,0,0};
    vt[13] = '{0,0,16'h0,    0,0,16'h0,    0,2, 6,2, 16'h6666,16'h2222,0,0,1};

    idle(); rd_num1 = 0; rd_num2 = 0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("reset_d1", d1[0], 16'h0);
    chk("reset_busy1", {15'h0, b1[0]}, 16'h0);
    chk("reset_claim_ready", {15'h0, cr[0]}, 16'h1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wa_en = vt[i].wa_en; wa_num = vt[i].wa_num; wa_data = vt[i].wa_data;
      wb_en = vt[i].wb_en; wb_num = vt[i].wb_num; wb_data = vt[i].wb_data;
      claim_en = vt[i].cl_en; claim_num = vt[i].cl_num;
      rd_num1 = vt[i].r1; rd_num2 = vt[i].r2;
      #1;
      chk($sformatf("v%0d_d1", i), d1[0], vt[i].e_d1);
      chk($sformatf("v%0d_d2", i), d2[0], vt[i].e_d2);
      chk($sformatf("v%0d_b1", i), {15'h0, b1[0]}, {15'h0, vt[i].e_b1});
      chk($sformatf("v%0d_b2", i), {15'h0, b2[0]}, {15'h0, vt[i].e_b2});
      chk($sformatf("v%0d_cr", i), {15'h0, cr[0]}, {15'h0, vt[i].e_cr});
    end

    // Non-bypassing file: write shows up a cycle late, busy clears a cycle late
    @(negedge clk); idle(); wa_en = 1; wa_num = 1; wa_data = 16'h5555; rd_num1 = 1; #1;
    chk("nb_write_old", d1[1], 16'h0000);
    chk("byp_write_same", d1[0], 16'h5555);
    @(negedge clk); idle(); #1;
    chk("nb_write_next", d1[1], 16'h5555);
    @(negedge clk); idle(); claim_en = 1; claim_num = 4;
    @(negedge clk); idle(); wb_en = 1; wb_num = 4; wb_data = 16'h4444; rd_num1 = 4; #1;
    chk("nb_busy_held", {15'h0, b1[1]}, 16'h1);
    chk("nb_data_held", d1[1], 16'h0000);
    chk("byp_busy_fwd", {15'h0, b1[0]}, 16'h0);
    @(negedge clk); idle(); #1;
    chk("nb_busy_next", {15'h0, b1[1]}, 16'h0);
    chk("nb_data_next", d1[1], 16'h4444);

    // Zero-register file: writes and claims to reg 0 vanish
    @(negedge clk); idle(); wa_en = 1; wa_num = 0; wa_data = 16'h7777;
    claim_en = 1; claim_num = 0; rd_num1 = 0; rd_num2 = 1; #1;
    chk("z_d1_same", d1[2], 16'h0000);
    chk("z_b1_same", {15'h0, b1[2]}, 16'h0);
    chk("z_cr_same", {15'h0, cr[2]}, 16'h1);
    chk("z_other_reg", d2[2], 16'h5555);
    chk("main_zero_fwd", d1[0], 16'h7777);
    @(negedge clk); idle(); #1;
    chk("z_d1_next", d1[2], 16'h0000);
    chk("z_b1_next", {15'h0, b1[2]}, 16'h0);
    chk("z_cr_next", {15'h0, cr[2]}, 16'h1);
    chk("main_reg0", d1[0], 16'h7777);
    chk("main_reg0_busy", {15'h0, b1[0]}, 16'h1);
    chk("main_cr0", {15'h0, cr[0]}, 16'h0);

    // Fill everything with 0xFFFF, hold a claim on 6, then reset mid-cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle(); wa_en = 1; wa_num = 3'(i); wa_data = 16'hFFFF;
      if (i == 0) begin claim_en = 1; claim_num = 6; end
    end
    @(negedge clk); idle(); claim_num = 6; rd_num1 = 5; rd_num2 = 6; #1;
    chk("pre_reset_d1", d1[0], 16'hFFFF);
    chk("pre_reset_cr", {15'h0, cr[0]}, 16'h0);
    #1 rst_n = 1'b0; #1;
    chk("async_reset_cr", {15'h0, cr[0]}, 16'h1);
    chk("async_reset_b2", {15'h0, b2[0]}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      rd_num1 = 3'(i); rd_num2 = 3'(7 - i); #1;
      chk($sformatf("rst_d1_r%0d", i), d1[0], 16'h0);
      chk($sformatf("rst_d2_r%0d", i), d2[0], 16'h0);
      chk($sformatf("rst_nb_d1_r%0d", i), d1[1], 16'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the CPU datapath, successor to the 4×16 two-port file. It has two combinational read ports and two independent write ports: A is the ALU result, B is memory load return. An optional same-cycle write-to-read bypass and an optional hardwired zero register are selected by parameters. A per-register scoreboard (busy bit) tracks outstanding loads, and the control unit uses it to stall on read-after-load hazards.

## Interface
Parameters:
- WIDTH, 16, data width of every register
- COUNT, 8, number of registers, power of two, ≥ 2; AW = clog2(COUNT)
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads show stored value only
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and claims to it are ignored

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_num1, rd_num2  in  AW  read selectors
- rd_data1, rd_data2  out  WIDTH  read data, combinational
- rd_busy1, rd_busy2  out  1  selected register has an outstanding load, combinational
- wa_en  in  1  write port A enable (ALU result)
- wa_num  in  AW  port A target
- wa_data  in  WIDTH  port A data
- wb_en  in  1  write port B enable (load return), also clears busy
- wb_num  in  AW  port B target
- wb_data  in  WIDTH  port B data
- claim_en  in  1  request to mark claim_num busy (load issued)
- claim_num  in  AW  register to claim
- claim_ready  out  1  claim_num is not busy, so a claim is accepted this cycle

## Operation
- Storage: COUNT×WIDTH registers plus a COUNT-bit busy vector.
- Write: on a rising edge, port A writes wa_data to wa_num if wa_en is high; port B writes wb_data to wb_num if wb_en is high.
- Write conflict: if wa_num == wb_num and both enables are high, port A data is stored. Busy is still cleared by port B.
- Busy clear: wb_en clears busy[wb_num]. Port A never changes busy.
- Busy set: claim_en && claim_ready sets busy[claim_num].
- claim_ready is combinational: !busy[claim_num], evaluated on the registered busy vector. With ZERO_REG=1 and claim_num==0, claim_ready=1 and no state changes.
- Claim while busy: the claim is not accepted, busy is unchanged, and the requester holds claim_en.
- Same-cycle clear and claim of one register: claim_ready is 0 because busy is still set, so the result is cleared (0).
- Reads with BYPASS=1:
  - rd_dataN = wa_data if wa_en && wa_num==rd_numN
  - else wb_data if wb_en && wb_num==rd_numN
  - else the stored value.
  - rd_busyN = busy[rd_numN] && !(wb_en && wb_num==rd_numN).
- Reads with BYPASS=0: rd_dataN and rd_busyN come from stored state only.
- ZERO_REG=1 with rd_numN==0: rd_dataN=0 and rd_busyN=0 regardless of bypass. Writes to register 0 are dropped.
- Both read ports may address the same register; each returns identical data.

## Timing
- Reset (rst_n low, asynchronous): all registers 0 and busy vector 0. Consequently rd_data1/2=0, rd_busy1/2=0 and claim_ready=1 while in reset.
- Reset deassertion: synchronised externally; first state update on the first rising edge with rst_n high.
- Reset mid-operation: pending claims are lost and busy is cleared; the control unit must drop in-flight loads.
- Write latency: stored on the edge. Visible on read ports the same cycle if BYPASS=1, otherwise the following cycle.
- Claim latency: busy is visible on rd_busy and claim_ready the cycle after acceptance.
- No handshake on the write ports; every enabled write is taken.

## Test plan
- Reset: load all 8 registers with 0xFFFF, pulse rst_n low mid-cycle. Every read must return 0x0000 and claim_ready must be 1 immediately, without waiting for a clock edge.
- Write conflict: wa_en=wb_en=1, wa_num=wb_num=3, wa_data=0x1234, wb_data=0xBEEF. Next cycle reg3 = 0x1234 and busy[3] = 0. With BYPASS=1, rd_num1=3 shows 0x1234 in the same cycle.
- Scoreboard:
  - Claim reg 5 → next cycle rd_busy1=1 and claim_ready for 5 is 0.
  - A second claim of 5 is rejected.
  - wb_en to 5 with 0x00AA → rd_busy1=0 in the same cycle (BYPASS=1), reg5 = 0x00AA the next cycle.
- Clear+claim: with busy[2]=1, assert wb_en to 2 and claim 2 in the same cycle → busy[2]=0 afterwards. Re-claim next cycle → busy[2]=1.
- BYPASS=0 instance: write 0x5555 to reg 1 → rd_data shows the old value that cycle and 0x5555 the next.
- ZERO_REG=1 instance: write 0x7777 and claim reg 0 → reads return 0, rd_busy=0, claim_ready=1. Other registers are unaffected.
